// File: rtl/codma_mc_engine.sv
// Multi-channel CODMA task engine: round-robin channel arbitration, 5-word descriptor fetch,
// burst data moves, linked chains. Define CODMA_CRC_EN to enable CRC-32 tasks (type 3).
module codma_mc_engine #(
  parameter int NUM_CH    = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NUM_CH-1:0]     start_i,
  input  logic [NUM_CH*32-1:0]  task_ptr_i,
  input  logic [NUM_CH-1:0]     irq_clr_i,
  output logic [NUM_CH-1:0]     busy_o,
  output logic [NUM_CH-1:0]     irq_o,
  output logic [NUM_CH-1:0]     err_o,
  output logic                  rd_req_o,
  input  logic                  rd_gnt_i,
  output logic [31:0]           rd_addr_o,
  output logic [4:0]            rd_len_o,
  input  logic                  rd_valid_i,
  input  logic [31:0]           rd_data_i,
  output logic                  wr_req_o,
  input  logic                  wr_gnt_i,
  output logic [31:0]           wr_addr_o,
  output logic [4:0]            wr_len_o,
  output logic [31:0]           wr_data_o,
  input  logic                  wr_ready_i,
  output logic [3:0]            dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ARB      = 4'd1;
  localparam logic [3:0] S_DESC_REQ = 4'd2;
  localparam logic [3:0] S_DESC_RD  = 4'd3;
  localparam logic [3:0] S_CHECK    = 4'd4;
  localparam logic [3:0] S_DATA_REQ = 4'd5;
  localparam logic [3:0] S_DATA_RD  = 4'd6;
  localparam logic [3:0] S_WR_REQ   = 4'd7;
  localparam logic [3:0] S_WR_DATA  = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam logic [3:0] S_ERROR    = 4'd10;

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

`ifdef CODMA_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic [3:0]        state;
  logic [31:0]       ptr [NUM_CH];
  logic [NUM_CH-1:0] busy, irq, err;
  logic [CW-1:0]     cur_ch, last_granted, arb_sel;
  logic              arb_found;
  logic [31:0]       typ, src, dst, len, nxt;
  logic [4:0]        cnt, burst_n;
  logic [31:0]       data_buf [BURST_MAX];
  logic [31:0]       crc;
  logic [31:0]       step, len_after;
  logic              crc_mode, bad_desc;

  function automatic logic [4:0] burst_of(input logic [31:0] t, input logic [29:0] words);
    if (t == 32'd0) return 5'd1;
    if (words >= 30'(BURST_MAX)) return 5'(BURST_MAX);
    return words[4:0];
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign step      = {25'd0, burst_n, 2'b00};
  assign len_after = len - step;
  assign crc_mode  = CRC_EN && (typ == 32'd3);
  assign bad_desc  = (typ > 32'd3) || ((typ == 32'd3) && !CRC_EN) || (len[1:0] != 2'b00);

  assign busy_o    = busy;
  assign irq_o     = irq;
  assign err_o     = err;
  assign dbg_state = state;
  assign wr_data_o = (state != S_WR_DATA) ? 32'd0 :
                     crc_mode ? ~crc : data_buf[cnt[BW-1:0]];

  // Search starts one past the last grant so every busy channel gets its turn.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(last_granted) + 1 + i) % NUM_CH;
      if (busy[CW'(idx)]) begin
        arb_found = 1'b1;
        arb_sel   = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_DATA_RD && rd_valid_i) data_buf[cnt[BW-1:0]] <= rd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      busy         <= '0;
      irq          <= '0;
      err          <= '0;
      cur_ch       <= '0;
      last_granted <= CW'(NUM_CH - 1);
      typ          <= '0;
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      nxt          <= '0;
      cnt          <= '0;
      burst_n      <= '0;
      crc          <= '0;
      rd_req_o     <= 1'b0;
      rd_addr_o    <= '0;
      rd_len_o     <= '0;
      wr_req_o     <= 1'b0;
      wr_addr_o    <= '0;
      wr_len_o     <= '0;
      for (int c = 0; c < NUM_CH; c++) ptr[c] <= '0;
    end else begin
      // Clears apply first; a set later in this block on the same bit takes precedence.
      irq <= irq & ~irq_clr_i;
      err <= err & ~irq_clr_i;
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_i[c] && !busy[c]) begin
          ptr[c]  <= task_ptr_i[32*c +: 32];
          busy[c] <= 1'b1;
        end
      end
      case (state)
        S_IDLE: if (|busy) state <= S_ARB;
        S_ARB: begin
          if (arb_found) begin
            cur_ch       <= arb_sel;
            last_granted <= arb_sel;
            rd_req_o     <= 1'b1;
            rd_addr_o    <= ptr[arb_sel];
            rd_len_o     <= 5'd5;
            cnt          <= '0;
            state        <= S_DESC_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DESC_REQ, S_DATA_REQ: begin
          if (rd_gnt_i) begin
            rd_req_o <= 1'b0;
            state    <= (state == S_DESC_REQ) ? S_DESC_RD : S_DATA_RD;
          end
        end
        S_DESC_RD: begin
          if (rd_valid_i) begin
            case (cnt)
              5'd0:    typ <= rd_data_i;
              5'd1:    src <= rd_data_i;
              5'd2:    dst <= rd_data_i;
              5'd3:    len <= rd_data_i;
              default: nxt <= rd_data_i;
            endcase
            if (cnt == 5'd4) begin
              cnt   <= '0;
              state <= S_CHECK;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_CHECK: begin
          if (bad_desc) begin
            state <= S_ERROR;
          end else if (len == 32'd0) begin
            state <= S_DONE;
          end else begin
            burst_n   <= burst_of(typ, len[31:2]);
            rd_len_o  <= burst_of(typ, len[31:2]);
            rd_addr_o <= src;
            rd_req_o  <= 1'b1;
            crc       <= 32'hFFFF_FFFF;
            state     <= S_DATA_REQ;
          end
        end
        S_DATA_RD: begin
          if (rd_valid_i) begin
            crc <= crc_step(crc, rd_data_i);
            if (cnt == burst_n - 5'd1) begin
              cnt <= '0;
              src <= src + step;
              len <= len_after;
              // CRC tasks keep reading until the source is exhausted, then write one word.
              if (crc_mode && len_after != 32'd0) begin
                burst_n   <= burst_of(typ, len_after[31:2]);
                rd_len_o  <= burst_of(typ, len_after[31:2]);
                rd_addr_o <= src + step;
                rd_req_o  <= 1'b1;
                state     <= S_DATA_REQ;
              end else begin
                burst_n   <= crc_mode ? 5'd1 : burst_n;
                wr_len_o  <= crc_mode ? 5'd1 : burst_n;
                wr_addr_o <= dst;
                wr_req_o  <= 1'b1;
                state     <= S_WR_REQ;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_WR_REQ: begin
          if (wr_gnt_i) begin
            wr_req_o <= 1'b0;
            cnt      <= '0;
            state    <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (wr_ready_i) begin
            if (cnt == burst_n - 5'd1) begin
              cnt <= '0;
              dst <= dst + step;
              if (len != 32'd0) begin
                burst_n   <= burst_of(typ, len[31:2]);
                rd_len_o  <= burst_of(typ, len[31:2]);
                rd_addr_o <= src;
                rd_req_o  <= 1'b1;
                state     <= S_DATA_REQ;
              end else if (typ == 32'd2 && nxt != 32'd0) begin
                rd_addr_o <= nxt;
                rd_len_o  <= 5'd5;
                rd_req_o  <= 1'b1;
                state     <= S_DESC_REQ;
              end else begin
                state <= S_DONE;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_DONE: begin
          busy[cur_ch] <= 1'b0;
          irq[cur_ch]  <= 1'b1;
          state        <= S_IDLE;
        end
        S_ERROR: begin
          busy[cur_ch] <= 1'b0;
          err[cur_ch]  <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codma_mc_engine.sv
// Directed bench for codma_mc_engine with behavioural read/write memory responders.
module tb_codma_mc_engine;
  localparam int NUM_CH = 4;
  localparam int BURST_MAX = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_CH-1:0]    start_i, irq_clr_i, busy_o, irq_o, err_o;
  logic [NUM_CH*32-1:0] task_ptr_i;
  logic                 rd_req_o, rd_gnt_i, rd_valid_i, wr_req_o, wr_gnt_i, wr_ready_i;
  logic [31:0]          rd_addr_o, rd_data_i, wr_addr_o, wr_data_o;
  logic [4:0]           rd_len_o, wr_len_o;
  logic [3:0]           dbg_state;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_len_q[$], wr_len_q[$], desc_q[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int desc_gap = -1;
  int last_beat_cyc = 0;
  int last_wr_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  codma_mc_engine #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_i), .task_ptr_i(task_ptr_i),
    .irq_clr_i(irq_clr_i), .busy_o(busy_o), .irq_o(irq_o), .err_o(err_o),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .wr_req_o(wr_req_o), .wr_gnt_i(wr_gnt_i), .wr_addr_o(wr_addr_o), .wr_len_o(wr_len_o),
    .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i), .dbg_state(dbg_state)
  );

  // clock / reset / monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dbg_state == 4'd9) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // read responder: grant, then deliver beats back to back
  initial begin
    int n, base, last_len;
    last_len = 0;
    rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
    forever begin
      @(negedge clk);
      rd_gnt_i = 1'b0; rd_valid_i = 1'b0;
      if (rd_req_o) begin
        n = int'(rd_len_o);
        base = int'(rd_addr_o[11:2]);
        if (last_len == 5) desc_gap = cyc - last_beat_cyc;
        rd_len_q.push_back({27'd0, rd_len_o});
        if (n == 5) desc_q.push_back(rd_addr_o);
        rd_gnt_i = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          rd_gnt_i = 1'b0;
          rd_valid_i = 1'b1;
          rd_data_i = mem[(base + i) % 1024];
          last_beat_cyc = cyc;
        end
        last_len = n;
      end
    end
  end

  // write responder: grant, then accept one beat per cycle
  initial begin
    int n, base;
    wr_gnt_i = 1'b0; wr_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      wr_gnt_i = 1'b0; wr_ready_i = 1'b0;
      if (wr_req_o) begin
        n = int'(wr_len_o);
        base = int'(wr_addr_o[11:2]);
        wr_len_q.push_back({27'd0, wr_len_o});
        wr_gnt_i = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          wr_gnt_i = 1'b0;
          wr_ready_i = 1'b1;
          mem[(base + i) % 1024] = wr_data_o;
          last_wr_cyc = cyc;
        end
      end
    end
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2);
    logic [95:0] s;
    logic [31:0] c;
    logic fb;
    s = {w0, w1, w2};
    c = 32'hFFFF_FFFF;
    for (int i = 95; i >= 0; i--) begin
      fb = c[31] ^ s[i];
      c = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return ~c;
  endfunction

  // driver tasks
  task automatic put_desc(input logic [31:0] a, input logic [31:0] t, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l, input logic [31:0] n);
    int b;
    b = int'(a[11:2]);
    mem[b] = t; mem[b+1] = s; mem[b+2] = d; mem[b+3] = l; mem[b+4] = n;
  endtask

  task automatic start_ch(input int c, input logic [31:0] p);
    task_ptr_i[32*c +: 32] = p;
    start_i[c] = 1'b1;
    @(negedge clk);
    start_i = '0;
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    irq_clr_i = m;
    @(negedge clk);
    irq_clr_i = '0;
  endtask

  task automatic wait_idle(input logic [3:0] mask, output int t);
    int k;
    k = 0;
    while ((busy_o & mask) != 4'b0000 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    t = cyc;
    n_cmp++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL wait_idle timeout busy=%b mask=%b", busy_o, mask);
    end
  endtask

  task automatic wait_state(input logic [3:0] s);
    int k;
    k = 0;
    while (dbg_state !== s && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL wait_state timeout state=%0d want=%0d", dbg_state, s);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy_o, irq_o, err_o} !== 12'h000) begin n_fail++;
      $display("FAIL reset_flags got=%h exp=000", {busy_o, irq_o, err_o}); end
    n_cmp++; if ({rd_req_o, wr_req_o} !== 2'b00) begin n_fail++;
      $display("FAIL reset_req got=%b exp=00", {rd_req_o, wr_req_o}); end
    n_cmp++; if ({rd_addr_o, wr_addr_o, wr_data_o} !== 96'd0) begin n_fail++;
      $display("FAIL reset_addr_data got=%h exp=0", {rd_addr_o, wr_addr_o, wr_data_o}); end
    n_cmp++; if ({rd_len_o, wr_len_o, dbg_state} !== 14'd0) begin n_fail++;
      $display("FAIL reset_len_state got=%h exp=0", {rd_len_o, wr_len_o, dbg_state}); end
  endtask

  task automatic test_type1();
    int t;
    for (int i = 0; i < 10; i++) mem[16'h40 + i] = 32'hA000_0000 + i;
    put_desc(32'h40, 32'd1, 32'h100, 32'h200, 32'd40, 32'd0);
    rd_len_q.delete(); wr_len_q.delete();
    start_ch(0, 32'h40);
    n_cmp++; if (busy_o !== 4'b0001) begin n_fail++;
      $display("FAIL type1_busy_rise got=%b exp=0001", busy_o); end
    wait_idle(4'b0001, t);
    exp_q = '{32'd5, 32'd8, 32'd2};
    n_cmp++; if (rd_len_q.size() != exp_q.size()) begin n_fail++;
      $display("FAIL type1_rd_count got=%0d exp=%0d", rd_len_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rd_len_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL type1_rd_len[%0d] got=%0d exp=%0d", i, rd_len_q[i], exp_q[i]); end
    end
    n_cmp++; if (wr_len_q.size() != 2 || wr_len_q[0] !== 32'd8 || wr_len_q[1] !== 32'd2) begin
      n_fail++; $display("FAIL type1_wr_lens got=%p exp=8,2", wr_len_q); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (mem[16'h80 + i] !== 32'hA000_0000 + i) begin n_fail++;
        $display("FAIL type1_dst[%0d] got=%h exp=%h", i, mem[16'h80 + i], 32'hA000_0000 + i); end
    end
    n_cmp++; if (desc_gap !== 2) begin n_fail++;
      $display("FAIL type1_desc_to_req got=%0d exp=2", desc_gap); end
    n_cmp++; if (t - last_wr_cyc !== 2) begin n_fail++;
      $display("FAIL type1_wr_to_irq got=%0d exp=2", t - last_wr_cyc); end
    n_cmp++; if ({busy_o, irq_o, err_o} !== 12'h010) begin n_fail++;
      $display("FAIL type1_flags got=%h exp=010", {busy_o, irq_o, err_o}); end
    pulse_clr(4'b1111);
    n_cmp++; if (irq_o !== 4'b0000) begin n_fail++;
      $display("FAIL type1_irq_clear got=%b exp=0000", irq_o); end
  endtask

  task automatic test_arbitration();
    int t;
    put_desc(32'h60, 32'd1, 32'h0, 32'h0, 32'd0, 32'd0);
    start_ch(1, 32'h60);
    wait_idle(4'b0010, t);
    n_cmp++; if (irq_o !== 4'b0010) begin n_fail++;
      $display("FAIL arb_noop_irq got=%b exp=0010", irq_o); end
    pulse_clr(4'b1111);
    mem[16'h50] = 32'h1111_0000; mem[16'h51] = 32'h1111_0001;
    mem[16'h58] = 32'h3333_0000; mem[16'h59] = 32'h3333_0001;
    put_desc(32'h80, 32'd1, 32'h140, 32'h240, 32'd8, 32'd0);
    put_desc(32'hA0, 32'd1, 32'h160, 32'h260, 32'd8, 32'd0);
    desc_q.delete();
    task_ptr_i[63:32] = 32'h80;
    task_ptr_i[127:96] = 32'hA0;
    start_i = 4'b1010;
    @(negedge clk);
    start_i = '0;
    wait_idle(4'b1010, t);
    exp_q = '{32'hA0, 32'h80};
    n_cmp++; if (desc_q.size() != 2 || desc_q[0] !== exp_q[0] || desc_q[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL arb_order got=%p exp=%p", desc_q, exp_q); end
    n_cmp++; if (irq_o !== 4'b1010) begin n_fail++;
      $display("FAIL arb_irqs got=%b exp=1010", irq_o); end
    n_cmp++; if (mem[16'h90] !== 32'h1111_0000 || mem[16'h91] !== 32'h1111_0001) begin n_fail++;
      $display("FAIL arb_ch1_data got=%h %h exp=11110000 11110001", mem[16'h90], mem[16'h91]); end
    n_cmp++; if (mem[16'h98] !== 32'h3333_0000 || mem[16'h99] !== 32'h3333_0001) begin n_fail++;
      $display("FAIL arb_ch3_data got=%h %h exp=33330000 33330001", mem[16'h98], mem[16'h99]); end
    pulse_clr(4'b1111);
  endtask

  task automatic test_chain();
    int t, base;
    for (int i = 0; i < 3; i++) mem[16'h100 + i] = 32'hC100_0000 + i;
    for (int i = 0; i < 2; i++) mem[16'h104 + i] = 32'hC200_0000 + i;
    mem[16'h108] = 32'hC300_0000;
    put_desc(32'h300, 32'd2, 32'h400, 32'h500, 32'd12, 32'h320);
    put_desc(32'h320, 32'd2, 32'h410, 32'h510, 32'd8, 32'h340);
    put_desc(32'h340, 32'd2, 32'h420, 32'h520, 32'd4, 32'h0);
    desc_q.delete(); rd_len_q.delete();
    base = done_cnt;
    start_ch(2, 32'h300);
    wait_idle(4'b0100, t);
    exp_q = '{32'h300, 32'h320, 32'h340};
    n_cmp++; if (desc_q.size() != 3) begin n_fail++;
      $display("FAIL chain_fetches got=%0d exp=3", desc_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (desc_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL chain_desc[%0d] got=%h exp=%h", i, desc_q[i], exp_q[i]); end
    end
    exp_q = '{32'd5, 32'd3, 32'd5, 32'd2, 32'd5, 32'd1};
    n_cmp++; if (rd_len_q != exp_q) begin n_fail++;
      $display("FAIL chain_rd_lens got=%p exp=%p", rd_len_q, exp_q); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem[16'h140 + i] !== 32'hC100_0000 + i) begin n_fail++;
        $display("FAIL chain_d1[%0d] got=%h", i, mem[16'h140 + i]); end
    end
    n_cmp++; if (mem[16'h144] !== 32'hC200_0000 || mem[16'h145] !== 32'hC200_0001 ||
                 mem[16'h148] !== 32'hC300_0000) begin n_fail++;
      $display("FAIL chain_d23 got=%h %h %h", mem[16'h144], mem[16'h145], mem[16'h148]); end
    n_cmp++; if (done_cnt - base !== 1) begin n_fail++;
      $display("FAIL chain_done_count got=%0d exp=1", done_cnt - base); end
    n_cmp++; if ({irq_o, err_o} !== 8'h40) begin n_fail++;
      $display("FAIL chain_flags got=%h exp=40", {irq_o, err_o}); end
    pulse_clr(4'b1111);
  endtask

  task automatic test_errors();
    int t;
    put_desc(32'hC0, 32'd1, 32'h100, 32'h280, 32'd6, 32'd0);
    rd_len_q.delete(); wr_len_q.delete();
    start_ch(0, 32'hC0);
    wait_idle(4'b0001, t);
    repeat (3) @(negedge clk);
    n_cmp++; if ({irq_o, err_o} !== 8'h01) begin n_fail++;
      $display("FAIL err_unaligned_flags got=%h exp=01", {irq_o, err_o}); end
    n_cmp++; if (rd_len_q.size() != 1 || wr_len_q.size() != 0) begin n_fail++;
      $display("FAIL err_unaligned_traffic rd=%0d wr=%0d exp=1,0", rd_len_q.size(), wr_len_q.size()); end
    put_desc(32'hE0, 32'd5, 32'h100, 32'h280, 32'd8, 32'd0);
    rd_len_q.delete();
    start_ch(1, 32'hE0);
    wait_idle(4'b0010, t);
    repeat (3) @(negedge clk);
    n_cmp++; if ({irq_o, err_o} !== 8'h03) begin n_fail++;
      $display("FAIL err_type5_flags got=%h exp=03", {irq_o, err_o}); end
    n_cmp++; if (rd_len_q.size() != 1 || wr_len_q.size() != 0) begin n_fail++;
      $display("FAIL err_type5_traffic rd=%0d wr=%0d exp=1,0", rd_len_q.size(), wr_len_q.size()); end
    pulse_clr(4'b0011);
    n_cmp++; if (err_o !== 4'b0000) begin n_fail++;
      $display("FAIL err_clear got=%b exp=0000", err_o); end
  endtask

  task automatic test_clr_collision();
    start_ch(0, 32'h40);
    wait_state(4'd9);
    irq_clr_i = 4'b0001;
    @(negedge clk);
    irq_clr_i = '0;
    n_cmp++; if ({busy_o[0], irq_o[0]} !== 2'b01) begin n_fail++;
      $display("FAIL collision_set_wins got=%b exp=01", {busy_o[0], irq_o[0]}); end
    pulse_clr(4'b0001);
    n_cmp++; if (irq_o !== 4'b0000) begin n_fail++;
      $display("FAIL collision_clear got=%b exp=0000", irq_o); end
    // immediate restart the cycle after busy fell
    start_ch(0, 32'h40);
    n_cmp++; if (busy_o !== 4'b0001) begin n_fail++;
      $display("FAIL restart_busy got=%b exp=0001", busy_o); end
  endtask

  task automatic test_reset_mid();
    wait_state(4'd8);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy_o, irq_o, err_o, rd_req_o, wr_req_o, dbg_state} !== 18'd0) begin n_fail++;
      $display("FAIL midreset_flags got=%h exp=0", {busy_o, irq_o, err_o, rd_req_o, wr_req_o, dbg_state}); end
    n_cmp++; if ({rd_addr_o, wr_addr_o, wr_data_o, rd_len_o, wr_len_o} !== 106'd0) begin n_fail++;
      $display("FAIL midreset_bus got=%h exp=0", {rd_addr_o, wr_addr_o, wr_data_o, rd_len_o, wr_len_o}); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if ({busy_o, irq_o} !== 8'h00) begin n_fail++;
      $display("FAIL midreset_no_irq got=%h exp=00", {busy_o, irq_o}); end
  endtask

  task automatic test_crc();
    int t;
    mem[16'h180] = 32'h3132_3334; mem[16'h181] = 32'h3536_3738; mem[16'h182] = 32'h3900_0000;
    mem[16'h1C0] = 32'hDEAD_BEEF;
    put_desc(32'hE0, 32'd3, 32'h600, 32'h700, 32'd12, 32'd0);
    rd_len_q.delete(); wr_len_q.delete();
    start_ch(1, 32'hE0);
    wait_idle(4'b0010, t);
    repeat (3) @(negedge clk);
`ifdef CODMA_CRC_EN
    n_cmp++; if ({irq_o, err_o} !== 8'h20) begin n_fail++;
      $display("FAIL crc_flags got=%h exp=20", {irq_o, err_o}); end
    n_cmp++; if (mem[16'h1C0] !== crc_ref(32'h3132_3334, 32'h3536_3738, 32'h3900_0000)) begin
      n_fail++; $display("FAIL crc_value got=%h exp=%h", mem[16'h1C0],
                         crc_ref(32'h3132_3334, 32'h3536_3738, 32'h3900_0000)); end
    n_cmp++; if (wr_len_q.size() != 1 || wr_len_q[0] !== 32'd1) begin n_fail++;
      $display("FAIL crc_wr_len got=%p exp=1", wr_len_q); end
`else
    n_cmp++; if ({irq_o, err_o} !== 8'h02) begin n_fail++;
      $display("FAIL crc_disabled_flags got=%h exp=02", {irq_o, err_o}); end
    n_cmp++; if (rd_len_q.size() != 1 || wr_len_q.size() != 0 || mem[16'h1C0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL crc_disabled_traffic rd=%0d wr=%0d dst=%h", rd_len_q.size(),
                         wr_len_q.size(), mem[16'h1C0]); end
`endif
    pulse_clr(4'b1111);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset_n = 1'b0; start_i = '0; irq_clr_i = '0; task_ptr_i = '0;
    @(negedge clk);
    test_reset();
    test_type1();
    test_arbitration();
    test_chain();
    test_errors();
    test_clr_collision();
    test_reset_mid();
    test_crc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
